// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states,
// response error codes and the alignment rule.
package lsu_pkg;

  typedef enum logic [2:0] {
    SZ_B    = 3'b000,
    SZ_H    = 3'b001,
    SZ_W    = 3'b010,
    SZ_BU   = 3'b100,
    SZ_HU   = 3'b101,
    SZ_NONE = 3'b111
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_e;

  // Illegal size codes report as misaligned so they never reach memory.
  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_B, SZ_BU: ok = 1'b1;
      SZ_H, SZ_HU: ok = ~addr_lo[0];
      SZ_W:        ok = (addr_lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatting: selects the byte/half lane of the aligned word
// and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[8*addr_lo +: 8];
  assign half_lane = word[16*addr_lo[1] +: 16];

  always_comb begin
    data = word;
    case (size)
      SZ_B:    data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      SZ_BU:   data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      SZ_H:    data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      SZ_HU:   data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and the cache/memory controller.
// Optional performance counters are built when LSU_PERF_CNT_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  stall_o,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_write,
  output logic [2:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  mem_busy
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_accesses,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_RESP  = ST_RESP;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]            state_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic                  done;

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .word    (mem_rdata),
    .data    (load_fmt)
  );

  assign cnt_nxt = cnt_q + CNT_W'(1);
  assign done    = mem_ready && !mem_busy;

  always_comb begin
    case (size_q)
      SZ_B, SZ_BU: wdata_rep = {4{wdata_q[7:0]}};
      SZ_H, SZ_HU: wdata_rep = {2{wdata_q[15:0]}};
      default:     wdata_rep = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          cnt_q <= '0;
          if (!is_aligned(size_q, addr_q[1:0])) begin
            err_q   <= ERR_MISALIGN;
            state_q <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_nxt;
          // Completion takes priority over a timeout landing in the same cycle.
          if (done) begin
            rdata_q <= write_q ? '0 : load_fmt;
            err_q   <= ERR_OK;
            state_q <= S_RESP;
          end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
            err_q   <= ERR_TIMEOUT;
            state_q <= S_RESP;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign stall_o    = (state_q == S_IDLE && req_valid) || state_q == S_CHECK || state_q == S_WAIT;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_write  = (state_q == S_WAIT) && write_q;
  assign mem_size   = (state_q == S_WAIT) ? size_q : SZ_NONE;
  assign mem_addr   = (state_q == S_WAIT) ? addr_q : '0;
  assign mem_wdata  = (state_q == S_WAIT) ? wdata_rep : '0;

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_accesses     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state_q == S_RESP && err_q == ERR_OK && perf_accesses != '1)
        perf_accesses <= perf_accesses + 32'd1;
      if (stall_o && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a default instance plus a TIMEOUT=4
// instance sharing the memory-side inputs.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid_t;
  logic        req_write;
  logic [2:0]  req_size;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready, mem_busy;

  logic        req_ready, stall_o, resp_valid, mem_write;
  logic [31:0] resp_rdata, mem_wdata;
  logic [1:0]  resp_err;
  logic [2:0]  mem_size;
  logic [16:0] mem_addr;

  logic        req_ready_t, stall_t, resp_valid_t, mem_write_t;
  logic [31:0] resp_rdata_t, mem_wdata_t;
  logic [1:0]  resp_err_t;
  logic [2:0]  mem_size_t;
  logic [16:0] mem_addr_t;

  logic        sel;
  logic        s_ready, s_stall, s_rv, s_mwr;
  logic [31:0] s_rd, s_mwd;
  logic [1:0]  s_err;
  logic [2:0]  s_msz;
  logic [16:0] s_mad;

  int n_checks = 0;
  int n_errors = 0;

  int          lat, nm, nns;
  logic [31:0] rd, mwd;
  logic [1:0]  er;
  logic [2:0]  msz;
  logic        mwr;
  logic [16:0] mad;
  int          rv_seen;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall_o(stall_o), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_write(mem_write),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy)
  );

  load_store_unit #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_t), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready_t), .stall_o(stall_t), .resp_valid(resp_valid_t),
    .resp_rdata(resp_rdata_t), .resp_err(resp_err_t), .mem_write(mem_write_t),
    .mem_size(mem_size_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy)
  );

  assign s_ready = sel ? req_ready_t  : req_ready;
  assign s_stall = sel ? stall_t      : stall_o;
  assign s_rv    = sel ? resp_valid_t : resp_valid;
  assign s_rd    = sel ? resp_rdata_t : resp_rdata;
  assign s_err   = sel ? resp_err_t   : resp_err;
  assign s_mwr   = sel ? mem_write_t  : mem_write;
  assign s_msz   = sel ? mem_size_t   : mem_size;
  assign s_mad   = sel ? mem_addr_t   : mem_addr;
  assign s_mwd   = sel ? mem_wdata_t  : mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge and follows it to its response.
  // rel > 0: at that cycle index mem_ready is raised and mem_busy dropped.
  task automatic run_req(input logic to, input logic w, input logic [2:0] sz,
                         input logic [16:0] a, input logic [31:0] wd, input int rel);
    logic found;
    @(negedge clk);
    sel = to;
    if (to) req_valid_t = 1'b1; else req_valid = 1'b1;
    req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    #1;
    chk("req_ready_idle", 32'(s_ready), 32'd1);
    chk("stall_on_accept", 32'(s_stall), 32'd1);
    nm = 0; nns = 0; found = 1'b0;
    mwd = '0; msz = 3'b111; mwr = 1'b0; mad = '0;
    lat = 0;
    for (int i = 1; i < 60 && !found; i++) begin
      @(negedge clk);
      req_valid = 1'b0; req_valid_t = 1'b0;
      lat = i;
      if (s_rv) begin
        found = 1'b1;
      end else begin
        if (s_msz != 3'b111) begin
          if (nm == 0) begin
            mwd = s_mwd; msz = s_msz; mwr = s_mwr; mad = s_mad;
          end
          nm++;
        end
        if (!s_stall) nns++;
        if (i == rel) begin
          mem_ready = 1'b1; mem_busy = 1'b0;
        end
      end
    end
    chk("resp_seen", 32'(s_rv), 32'd1);
    rd = s_rd; er = s_err;
    chk("stall_in_resp", 32'(s_stall), 32'd0);
    chk("stall_before_resp", 32'(nns), 32'd0);
    @(negedge clk);
    chk("resp_one_pulse", 32'(s_rv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_valid_t = 1'b0; req_write = 1'b0;
    req_size = 3'b000; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0; mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_size", 32'(mem_size), 32'h7);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;

    // LB at 3: top lane 0x80 sign-extended, best-case latency
    mem_rdata = 32'h80FF_1234; mem_ready = 1'b1;
    run_req(1'b0, 1'b0, 3'b000, 17'h00003, 32'h0, 0);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    chk("lb_err", 32'(er), 32'd0);
    chk("lb_mem_size", 32'(msz), 32'h0);
    chk("lb_mem_addr", 32'(mad), 32'h3);
    chk("lb_mem_write", 32'(mwr), 32'd0);

    run_req(1'b0, 1'b0, 3'b100, 17'h00003, 32'h0, 0);
    chk("lbu_rdata", rd, 32'h0000_0080);

    mem_rdata = 32'hBEEF_0001;
    run_req(1'b0, 1'b0, 3'b101, 17'h00002, 32'h0, 0);
    chk("lhu_rdata", rd, 32'h0000_BEEF);
    run_req(1'b0, 1'b0, 3'b001, 17'h00002, 32'h0, 0);
    chk("lh_rdata", rd, 32'hFFFF_BEEF);
    run_req(1'b0, 1'b0, 3'b001, 17'h00000, 32'h0, 0);
    chk("lh_low_rdata", rd, 32'h0000_0001);
    run_req(1'b0, 1'b0, 3'b010, 17'h00000, 32'h0, 0);
    chk("lw_rdata", rd, 32'hBEEF_0001);

    // SB with memory held off for five WAIT cycles
    mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    run_req(1'b0, 1'b1, 3'b000, 17'h00001, 32'h0000_00A5, 7);
    chk("sb_lat", 32'(lat), 32'd8);
    chk("sb_wait_cycles", 32'(nm), 32'd6);
    chk("sb_mem_write", 32'(mwr), 32'd1);
    chk("sb_mem_size", 32'(msz), 32'h0);
    chk("sb_mem_wdata", mwd, 32'hA5A5_A5A5);
    chk("sb_mem_addr", 32'(mad), 32'h1);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_err", 32'(er), 32'd0);

    mem_ready = 1'b1;
    run_req(1'b0, 1'b1, 3'b001, 17'h00002, 32'h1234_BEEF, 0);
    chk("sh_mem_wdata", mwd, 32'hBEEF_BEEF);
    chk("sh_rdata", rd, 32'h0);
    run_req(1'b0, 1'b1, 3'b010, 17'h00004, 32'h1234_5678, 0);
    chk("sw_mem_wdata", mwd, 32'h1234_5678);

    // Misaligned and illegal sizes never touch memory
    run_req(1'b0, 1'b0, 3'b010, 17'h00006, 32'h0, 0);
    chk("mis_lw_lat", 32'(lat), 32'd2);
    chk("mis_lw_err", 32'(er), 32'd1);
    chk("mis_lw_no_access", 32'(nm), 32'd0);
    chk("mis_lw_rdata", rd, 32'h0);
    run_req(1'b0, 1'b0, 3'b101, 17'h00001, 32'h0, 0);
    chk("mis_lhu_err", 32'(er), 32'd1);
    run_req(1'b0, 1'b0, 3'b011, 17'h00000, 32'h0, 0);
    chk("illegal_size_err", 32'(er), 32'd1);
    chk("illegal_size_no_access", 32'(nm), 32'd0);

    // Ready while busy is ignored
    mem_ready = 1'b1; mem_busy = 1'b1;
    run_req(1'b0, 1'b0, 3'b010, 17'h00008, 32'h0, 4);
    chk("busy_lat", 32'(lat), 32'd5);
    chk("busy_rdata", rd, 32'hDEAD_BEEF);

    // Timeout instance: stuck memory, then completion on the timeout edge
    mem_ready = 1'b0; mem_busy = 1'b0;
    run_req(1'b1, 1'b0, 3'b010, 17'h00004, 32'h0, 0);
    chk("to_lat", 32'(lat), 32'd6);
    chk("to_err", 32'(er), 32'd2);
    chk("to_wait_cycles", 32'(nm), 32'd4);
    chk("to_rdata", rd, 32'h0);
    mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
    run_req(1'b1, 1'b0, 3'b010, 17'h00004, 32'h0, 5);
    chk("to_edge_lat", 32'(lat), 32'd6);
    chk("to_edge_err", 32'(er), 32'd0);
    chk("to_edge_rdata", rd, 32'h1234_5678);
    sel = 1'b0;

    // Reset in the middle of WAIT
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 3'b010; req_addr = 17'h00008;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", 32'(mem_size), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_size_async", 32'(mem_size), 32'h7);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    chk("abort_no_resp", 32'(rv_seen), 32'd0);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    mem_rdata = 32'hCAFE_F00D;
    run_req(1'b0, 1'b0, 3'b010, 17'h00004, 32'h0, 0);
    chk("post_abort_lat", 32'(lat), 32'd3);
    chk("post_abort_rdata", rd, 32'hCAFE_F00D);
    chk("post_abort_err", 32'(er), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
